// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared widths, port ids and completion-tag layout for the memory port arbiter
//
// Purpose: common definitions imported by mem_port_arbiter and mem_tag_pipe.
//   ADDR_W / DATA_W : RAM word address and data widths
//   PORT_CPU/PORT_VID: requester ids carried in the completion tag
//   tag_t           : {port, is_write, oob}; port is the MSB, oob the LSB
package mem_bus_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  typedef struct packed {
    logic port;      // bit 2
    logic is_write;  // bit 1
    logic oob;       // bit 0
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  function automatic tag_t make_tag(input logic port, input logic is_write, input logic oob);
    tag_t t;
    t.port     = port;
    t.is_write = is_write;
    t.oob      = oob;
    return t;
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// rtl/mem_tag_pipe.sv - fixed-depth shift register carrying {valid, tag} alongside RAM accesses
//
// Purpose: delays each grant's completion tag so it emerges in the cycle the RAM read
//   data for that access is valid.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset (empties the pipe)
//   i_valid, i_data  : tag entering stage 0
//   o_valid, o_data  : tag leaving the last stage (DEPTH cycles later)
module mem_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core / video arbiter onto one synchronous single-port RAM
//
// Purpose: grants at most one of the two requesters per cycle (video preferred, core
//   protected by a starvation limit), issues the access on registered RAM outputs and
//   returns a one-cycle ack RAM_LATENCY+2 cycles after the grant cycle.
// Ports:
//   i_clock, i_reset               : clock, synchronous active-high reset
//   i_cpu_req/we/addr/wdata        : core request (held until after ack)
//   o_cpu_rdata/ack/oob            : core completion; oob flags an address >= RAM_DEPTH
//   i_vid_req/addr                 : video read request
//   o_vid_rdata/ack                : video completion
//   o_ram_addr/din/we, i_ram_dout  : RAM interface
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int RAM_DEPTH      = 16384,
  parameter int RAM_LATENCY    = 1,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_oob,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [DATA_W-1:0] o_vid_rdata,
  output logic              o_vid_ack,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_dout
);

  localparam int                  STREAK_W   = $clog2(CPU_STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_STARVE_MAX);
  localparam int                  PIPE_DEPTH = 1 + RAM_LATENCY;

  function automatic logic is_oob(input logic [ADDR_W-1:0] a);
    return 32'(a) >= RAM_DEPTH;
  endfunction

  logic                r_cpu_busy;
  logic                r_vid_busy;
  logic [STREAK_W-1:0] r_vid_streak;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_ram_we;
  logic                r_cpu_ack;
  logic                r_cpu_oob;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_vid_ack;
  logic [DATA_W-1:0]   r_vid_rdata;

  logic             w_cpu_elig;
  logic             w_vid_elig;
  logic             w_starved;
  logic             w_grant_vid;
  logic             w_grant_cpu;
  logic             w_grant_any;
  logic             w_cpu_oob;
  logic             w_vid_oob;
  logic             w_cpu_wr;
  tag_t             w_tag_in;
  logic             w_tag_valid;
  logic [TAG_W-1:0] w_tag_bits;
  tag_t             w_tag_out;
  logic             w_done_cpu;
  logic             w_done_vid;
  logic             w_done_rd;

  // Busy covers the whole flight plus the ack cycle, so a held request cannot be
  // re-granted until the requester has had its ack.
  assign w_cpu_elig = i_cpu_req & ~r_cpu_busy;
  assign w_vid_elig = i_vid_req & ~r_vid_busy;
  assign w_starved  = (r_vid_streak == STREAK_MAX);

  assign w_grant_vid = w_vid_elig & (~w_cpu_elig | ~w_starved);
  assign w_grant_cpu = w_cpu_elig & ~w_grant_vid;
  assign w_grant_any = w_grant_vid | w_grant_cpu;

  assign w_cpu_oob = is_oob(i_cpu_addr);
  assign w_vid_oob = is_oob(i_vid_addr);
  assign w_cpu_wr  = w_grant_cpu & i_cpu_we & ~w_cpu_oob;

  assign w_tag_in = make_tag(w_grant_vid ? PORT_VID : PORT_CPU,
                             w_grant_cpu & i_cpu_we,
                             w_grant_vid ? w_vid_oob : w_cpu_oob);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cpu_busy   <= 1'b0;
      r_vid_busy   <= 1'b0;
      r_vid_streak <= '0;
    end else begin
      // Grant and ack never coincide on one port, since busy blocks the grant.
      if (w_grant_cpu)    r_cpu_busy <= 1'b1;
      else if (r_cpu_ack) r_cpu_busy <= 1'b0;
      if (w_grant_vid)    r_vid_busy <= 1'b1;
      else if (r_vid_ack) r_vid_busy <= 1'b0;

      if (w_grant_cpu || !w_cpu_elig) begin
        r_vid_streak <= '0;
      end else if (w_grant_vid && !w_starved) begin
        r_vid_streak <= r_vid_streak + 1'b1;
      end
    end
  end

  // Idle cycles drive zero address/data so the RAM bus is quiet between accesses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ram_addr <= w_grant_vid ? i_vid_addr : (w_grant_cpu ? i_cpu_addr : '0);
      r_ram_din  <= w_cpu_wr ? i_cpu_wdata : '0;
      r_ram_we   <= w_cpu_wr;
    end
  end

  mem_tag_pipe #(
    .DEPTH (PIPE_DEPTH),
    .W     (TAG_W)
  ) u_tag_pipe (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_valid (w_grant_any),
    .i_data  (w_tag_in),
    .o_valid (w_tag_valid),
    .o_data  (w_tag_bits)
  );

  // The tag leaves the pipe in the cycle i_ram_dout holds that access's data.
  assign w_tag_out  = tag_t'(w_tag_bits);
  assign w_done_cpu = w_tag_valid & (w_tag_out.port == PORT_CPU);
  assign w_done_vid = w_tag_valid & (w_tag_out.port == PORT_VID);
  assign w_done_rd  = ~w_tag_out.is_write & ~w_tag_out.oob;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cpu_ack   <= 1'b0;
      r_cpu_oob   <= 1'b0;
      r_cpu_rdata <= '0;
      r_vid_ack   <= 1'b0;
      r_vid_rdata <= '0;
    end else begin
      r_cpu_ack   <= w_done_cpu;
      r_cpu_oob   <= w_done_cpu & w_tag_out.oob;
      r_cpu_rdata <= (w_done_cpu && w_done_rd) ? i_ram_dout : '0;
      r_vid_ack   <= w_done_vid;
      r_vid_rdata <= (w_done_vid && w_done_rd) ? i_ram_dout : '0;
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_din   = r_ram_din;
  assign o_ram_we    = r_ram_we;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_oob   = r_cpu_oob;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_vid_ack   = r_vid_ack;
  assign o_vid_rdata = r_vid_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a cycle-count reference model
module tb_mem_port_arbiter;

  localparam int NCYC  = 2048;
  localparam int DEPTH = 16384;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;
  localparam int STV_A = 4;
  localparam int STV_B = 1;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        preload   = 1'b1;
  logic        cpu_req   = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [14:0] cpu_addr  = '0;
  logic [15:0] cpu_wdata = '0;
  logic        vid_req   = 1'b0;
  logic [14:0] vid_addr  = '0;

  logic [15:0] cpu_rdata [2];
  logic [15:0] vid_rdata [2];
  logic [15:0] ram_din   [2];
  logic [15:0] ram_dout  [2];
  logic [14:0] ram_addr  [2];
  logic        cpu_ack   [2];
  logic        cpu_oob   [2];
  logic        vid_ack   [2];
  logic        ram_we    [2];

  always #5 clock = ~clock;

  mem_port_arbiter #(.RAM_DEPTH(DEPTH), .RAM_LATENCY(LAT_A), .CPU_STARVE_MAX(STV_A)) dut_a (
    .i_clock(clock), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata[0]), .o_cpu_ack(cpu_ack[0]), .o_cpu_oob(cpu_oob[0]),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_rdata(vid_rdata[0]), .o_vid_ack(vid_ack[0]),
    .o_ram_addr(ram_addr[0]), .o_ram_din(ram_din[0]), .o_ram_we(ram_we[0]), .i_ram_dout(ram_dout[0])
  );

  mem_port_arbiter #(.RAM_DEPTH(DEPTH), .RAM_LATENCY(LAT_B), .CPU_STARVE_MAX(STV_B)) dut_b (
    .i_clock(clock), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata[1]), .o_cpu_ack(cpu_ack[1]), .o_cpu_oob(cpu_oob[1]),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_rdata(vid_rdata[1]), .o_vid_ack(vid_ack[1]),
    .o_ram_addr(ram_addr[1]), .o_ram_din(ram_din[1]), .o_ram_we(ram_we[1]), .i_ram_dout(ram_dout[1])
  );

  function automatic logic [15:0] init_word(input int a);
    if (a == 32'h2400) return 16'hBEEF;
    return 16'(a * 40503 + 4951);
  endfunction

  // Synchronous RAMs: one per DUT, latency 1 and 2 respectively.
  logic [15:0] ram [2][DEPTH];
  logic [15:0] rd0 [2];
  logic [15:0] rd1 [2];

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        for (int a = 0; a < DEPTH; a++) ram[k][a] <= init_word(a);
      end else if (ram_we[k] === 1'b1) begin
        ram[k][ram_addr[k][13:0]] <= ram_din[k];
      end
      rd0[k] <= ram[k][ram_addr[k][13:0]];
      rd1[k] <= rd0[k];
    end
  end

  assign ram_dout[0] = rd0[0];
  assign ram_dout[1] = rd1[1];

  // Reference model: per port, the last cycle it counts as busy; expected outputs
  // recorded per cycle number; memory updated in grant order.
  int          cyc = -1;
  int          busy_c [2];
  int          busy_v [2];
  int          streak [2];
  logic [15:0] mdl    [2][DEPTH];
  logic        e_cack [2][NCYC];
  logic        e_coob [2][NCYC];
  logic [15:0] e_crd  [2][NCYC];
  logic        e_vack [2][NCYC];
  logic [15:0] e_vrd  [2][NCYC];
  logic        e_we   [2][NCYC];
  logic [14:0] e_addr [2][NCYC];
  logic [15:0] e_din  [2][NCYC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_exp(input int k, input int c);
    e_cack[k][c] = 1'b0; e_coob[k][c] = 1'b0; e_crd[k][c] = '0;
    e_vack[k][c] = 1'b0; e_vrd[k][c]  = '0;
    e_we[k][c]   = 1'b0; e_addr[k][c] = '0;   e_din[k][c] = '0;
  endtask

  task automatic model_step(input int k, input int lat, input int smax);
    logic ce, ve, gv, gc, oob;
    int   t_ack;
    if (reset) begin
      for (int c = cyc + 1; c <= cyc + 8 && c < NCYC; c++) clear_exp(k, c);
      busy_c[k] = -1;
      busy_v[k] = -1;
      streak[k] = 0;
    end else begin
      ce    = cpu_req && (cyc > busy_c[k]);
      ve    = vid_req && (cyc > busy_v[k]);
      gv    = ve && !(ce && streak[k] == smax);
      gc    = ce && !gv;
      t_ack = cyc + 2 + lat;
      if (gc || !ce) streak[k] = 0;
      else if (gv && streak[k] < smax) streak[k]++;
      if (gv) begin
        busy_v[k]        = t_ack;
        e_addr[k][cyc+1] = vid_addr;
        e_vack[k][t_ack] = 1'b1;
        e_vrd[k][t_ack]  = (int'(vid_addr) < DEPTH) ? mdl[k][vid_addr[13:0]] : 16'h0000;
      end
      if (gc) begin
        oob              = int'(cpu_addr) >= DEPTH;
        busy_c[k]        = t_ack;
        e_addr[k][cyc+1] = cpu_addr;
        e_we[k][cyc+1]   = cpu_we && !oob;
        e_din[k][cyc+1]  = (cpu_we && !oob) ? cpu_wdata : 16'h0000;
        e_cack[k][t_ack] = 1'b1;
        e_coob[k][t_ack] = oob;
        e_crd[k][t_ack]  = (!cpu_we && !oob) ? mdl[k][cpu_addr[13:0]] : 16'h0000;
        if (cpu_we && !oob) mdl[k][cpu_addr[13:0]] = cpu_wdata;
      end
    end
  endtask

  task automatic check_cycle(input int k);
    string nm;
    nm = (k == 0) ? "lat1" : "lat2";
    check($sformatf("%s.cpu_ack", nm),   32'(cpu_ack[k]),   32'(e_cack[k][cyc]));
    check($sformatf("%s.cpu_oob", nm),   32'(cpu_oob[k]),   32'(e_coob[k][cyc]));
    check($sformatf("%s.cpu_rdata", nm), 32'(cpu_rdata[k]), 32'(e_crd[k][cyc]));
    check($sformatf("%s.vid_ack", nm),   32'(vid_ack[k]),   32'(e_vack[k][cyc]));
    check($sformatf("%s.vid_rdata", nm), 32'(vid_rdata[k]), 32'(e_vrd[k][cyc]));
    check($sformatf("%s.ram_we", nm),    32'(ram_we[k]),    32'(e_we[k][cyc]));
    check($sformatf("%s.ram_addr", nm),  32'(ram_addr[k]),  32'(e_addr[k][cyc]));
    check($sformatf("%s.ram_din", nm),   32'(ram_din[k]),   32'(e_din[k][cyc]));
  endtask

  task automatic run_cycle(input logic rst, input logic cr, input logic cw, input logic [14:0] ca,
                           input logic [15:0] cd, input logic vr, input logic [14:0] va);
    @(posedge clock);
    #1;
    cyc++;
    reset     = rst;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    vid_req   = vr;
    vid_addr  = va;
    model_step(0, LAT_A, STV_A);
    model_step(1, LAT_B, STV_B);
    @(negedge clock);
    if (cyc >= 1) begin
      check_cycle(0);
      check_cycle(1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic        cr, cw, vr, rst;
    logic [14:0] ca, va;
    logic [15:0] cd;
    int          bad;

    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCYC; c++) clear_exp(k, c);
      for (int a = 0; a < DEPTH; a++) mdl[k][a] = init_word(a);
      busy_c[k] = -1;
      busy_v[k] = -1;
      streak[k] = 0;
    end

    run_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    preload = 1'b0;
    run_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(2);

    // Single core read of a preloaded word.
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 15'h2400, '0, 1'b0, '0);
    idle(4);
    // Write then read back.
    repeat (4) run_cycle(1'b0, 1'b1, 1'b1, 15'h0010, 16'h1234, 1'b0, '0);
    idle(4);
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 15'h0010, '0, 1'b0, '0);
    idle(4);
    // Out-of-range core write and read, out-of-range video read.
    repeat (4) run_cycle(1'b0, 1'b1, 1'b1, 15'h5000, 16'hDEAD, 1'b0, '0);
    idle(4);
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 15'h5000, '0, 1'b0, '0);
    idle(4);
    repeat (4) run_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 15'h7FFF);
    idle(4);
    // Both requesters held continuously.
    repeat (40) run_cycle(1'b0, 1'b1, 1'b0, 15'h2400, '0, 1'b1, 15'h0010);
    idle(6);
    // Reset one cycle after a core grant, then a fresh request.
    run_cycle(1'b0, 1'b1, 1'b0, 15'h0123, '0, 1'b0, '0);
    run_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    run_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(5);
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 15'h0010, '0, 1'b0, '0);
    idle(4);

    // Random traffic: requests raised with fresh fields, held, occasionally dropped early.
    cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; vr = 1'b0; va = '0;
    for (int i = 0; i < 1200; i++) begin
      if (!cr) begin
        if ($urandom_range(0, 2) != 0) begin
          cr = 1'b1;
          cw = 1'($urandom_range(0, 1));
          ca = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 15)) : 15'($urandom);
          cd = 16'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        cr = 1'b0;
      end
      if (!vr) begin
        if ($urandom_range(0, 2) != 0) begin
          vr = 1'b1;
          va = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 15)) : 15'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        vr = 1'b0;
      end
      rst = ($urandom_range(0, 199) == 0);
      run_cycle(rst, cr, cw, ca, cd, vr, va);
    end
    idle(8);

    for (int k = 0; k < 2; k++) begin
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
        if (ram[k][a] !== mdl[k][a]) bad++;
      end
      check($sformatf("ram_image%0d", k), 32'(bad), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
